// File: rtl/key_switch_conditioner.sv
// Synchronise, debounce and edge-detect the DE2 KEY/SW inputs ahead of the keys/switches PIOs.
// Optional build macro KEY_AUTOREPEAT_EN adds per-key auto-repeat of key_press.
module key_switch_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_KEYS-1:0] keys_export,
  output logic [NUM_SW-1:0]   switches_export,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                sw_change
);

  localparam int N  = NUM_KEYS + NUM_SW;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Keys idle high (released), switches idle low.
  localparam logic [N-1:0]  RST_VAL = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};

  logic [N-1:0]        raw;
  logic [N-1:0]        s1_q, s2_q;
  logic [N-1:0]        stable_q, stable_d;
  logic [CW-1:0]       cnt_q [N];
  logic [CW-1:0]       cnt_d [N];
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic                sw_change_q, sw_change_d;
  logic [NUM_KEYS-1:0] fall;

  assign raw = {sw_raw, key_n_raw};

  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = s2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
    fall        = stable_q[NUM_KEYS-1:0] & ~stable_d[NUM_KEYS-1:0];
    release_d   = ~stable_q[NUM_KEYS-1:0] & stable_d[NUM_KEYS-1:0];
    sw_change_d = |(stable_q[N-1:NUM_KEYS] ^ stable_d[N-1:NUM_KEYS]);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0] DELAY_M1  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_M1 = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]       rep_cnt_q [NUM_KEYS];
  logic [RW-1:0]       rep_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_first_q, rep_first_d;

  // rep_first selects the initial delay; afterwards the shorter period applies.
  always_comb begin
    press_d     = fall;
    rep_first_d = rep_first_q;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      rep_cnt_d[k] = rep_cnt_q[k];
      if (stable_d[k] || fall[k]) begin
        rep_cnt_d[k]   = '0;
        rep_first_d[k] = 1'b1;
      end else if (rep_first_q[k] && rep_cnt_q[k] == DELAY_M1) begin
        press_d[k]     = 1'b1;
        rep_cnt_d[k]   = '0;
        rep_first_d[k] = 1'b0;
      end else if (!rep_first_q[k] && rep_cnt_q[k] == PERIOD_M1) begin
        press_d[k]     = 1'b1;
        rep_cnt_d[k]   = '0;
      end else begin
        rep_cnt_d[k]   = rep_cnt_q[k] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rep_first_q <= '1;
      for (int unsigned k = 0; k < NUM_KEYS; k++) rep_cnt_q[k] <= '0;
    end else begin
      rep_first_q <= rep_first_d;
      for (int unsigned k = 0; k < NUM_KEYS; k++) rep_cnt_q[k] <= rep_cnt_d[k];
    end
  end
`else
  always_comb press_d = fall;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_q        <= RST_VAL;
      s2_q        <= RST_VAL;
      stable_q    <= RST_VAL;
      press_q     <= '0;
      release_q   <= '0;
      sw_change_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      release_q   <= release_d;
      sw_change_q <= sw_change_d;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign keys_export     = stable_q[NUM_KEYS-1:0];
  assign switches_export = stable_q[N-1:NUM_KEYS];
  assign key_press       = press_q;
  assign key_release     = release_q;
  assign sw_change       = sw_change_q;

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Scoreboard bench for key_switch_conditioner: window-based debounce model feeds an event queue.
module tb_key_switch_conditioner;
  localparam int K  = 3;
  localparam int S  = 18;
  localparam int N  = K + S;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [N-1:0] RST_VAL = {{S{1'b0}}, {K{1'b1}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [K-1:0] key_n_raw = '1;
  logic [S-1:0] sw_raw = '0;
  logic [K-1:0] keys_export, key_press, key_release;
  logic [S-1:0] switches_export;
  logic         sw_change;

  key_switch_conditioner #(
    .NUM_KEYS(K), .NUM_SW(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .key_n_raw(key_n_raw), .sw_raw(sw_raw),
    .keys_export(keys_export), .switches_export(switches_export),
    .key_press(key_press), .key_release(key_release), .sw_change(sw_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  cyc;
    logic [K-1:0] keys;
    logic [S-1:0] sw;
    logic [K-1:0] press;
    logic [K-1:0] rel;
    logic         swc;
  } ev_t;

  ev_t sbq[$];
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic rst_seen = 1'b1;

  // Reference: a bit flips once the last D synchronised samples all disagree with it.
  logic [N-1:0] rawhist[$];
  logic [N-1:0] seen[$];
  logic [N-1:0] m_stable = RST_VAL;
  int unsigned  press_t [K];

  always @(posedge clk) begin
    logic [N-1:0] nxt, s2v;
    logic [K-1:0] pr, rl;
    logic         sc, all_diff;
    ev_t          e;
    cyc++;
    rst_seen = rst;
    nxt = m_stable;
    if (rst) begin
      rawhist = '{RST_VAL, RST_VAL};
      seen.delete();
      nxt = RST_VAL;
    end else begin
      s2v = rawhist.pop_front();
      rawhist.push_back({sw_raw, key_n_raw});
      seen.push_back(s2v);
      if (seen.size() > D) void'(seen.pop_front());
      if (seen.size() == D) begin
        for (int b = 0; b < N; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (seen[j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) nxt[b] = ~m_stable[b];
        end
      end
    end
    pr = rst ? '0 : (m_stable[K-1:0] & ~nxt[K-1:0]);
    rl = rst ? '0 : (~m_stable[K-1:0] & nxt[K-1:0]);
    sc = rst ? 1'b0 : (m_stable[N-1:K] != nxt[N-1:K]);
    for (int k = 0; k < K; k++) if (pr[k]) press_t[k] = cyc;
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < K; k++) begin
      int unsigned dt;
      dt = cyc - press_t[k];
      if (!rst && !m_stable[k] && !nxt[k] &&
          (dt == RD || (dt > RD && (dt - RD) % RP == 0))) pr[k] = 1'b1;
    end
`endif
    if (nxt != m_stable || pr != '0 || rl != '0 || sc) begin
      e.cyc = cyc; e.keys = nxt[K-1:0]; e.sw = nxt[N-1:K];
      e.press = pr; e.rel = rl; e.swc = sc;
      sbq.push_back(e);
    end
    m_stable = nxt;
  end

  logic [N-1:0] last_out = RST_VAL;

  always @(negedge clk) begin
    logic present;
    ev_t  e;
    if (rst_seen) begin
      checks++;
      if (keys_export !== '1 || switches_export !== '0 || key_press !== '0 ||
          key_release !== '0 || sw_change !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got keys=%h sw=%h pr=%h rl=%h sc=%b want keys=7 sw=0 pulses=0",
                 cyc, keys_export, switches_export, key_press, key_release, sw_change);
      end
    end
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++; errors++;
      $display("FAIL missing_event cyc=%0d got nothing want keys=%h sw=%h pr=%h rl=%h sc=%b",
               e.cyc, e.keys, e.sw, e.press, e.rel, e.swc);
    end
    present = ({switches_export, keys_export} !== last_out) || (key_press !== '0) ||
              (key_release !== '0) || (sw_change !== 1'b0);
    if (present) begin
      checks++;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        if (keys_export !== e.keys || switches_export !== e.sw || key_press !== e.press ||
            key_release !== e.rel || sw_change !== e.swc) begin
          errors++;
          $display("FAIL event cyc=%0d got keys=%h sw=%h pr=%h rl=%h sc=%b want keys=%h sw=%h pr=%h rl=%h sc=%b",
                   cyc, keys_export, switches_export, key_press, key_release, sw_change,
                   e.keys, e.sw, e.press, e.rel, e.swc);
        end
      end else begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got keys=%h sw=%h pr=%h rl=%h sc=%b want no event",
                 cyc, keys_export, switches_export, key_press, key_release, sw_change);
      end
    end
    last_out = {switches_export, keys_export};
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned r, b;
    tick(3);
    rst = 1'b0;
    tick(3);
    key_n_raw[0] = 1'b0; tick(12);
    key_n_raw[0] = 1'b1; tick(12);
    key_n_raw[1] = 1'b0; tick(3);
    key_n_raw[1] = 1'b1; tick(1);
    key_n_raw[1] = 1'b0; tick(2);
    key_n_raw[1] = 1'b1; tick(1);
    key_n_raw[1] = 1'b0; tick(12);
    key_n_raw[1] = 1'b1; tick(12);
    sw_raw[17] = 1'b1; tick(3);
    sw_raw[17] = 1'b0; tick(12);
    sw_raw[17] = 1'b1; tick(12);
    sw_raw[17] = 1'b0; tick(12);
    key_n_raw = 3'b010; tick(12);
    key_n_raw = 3'b111; tick(12);
    key_n_raw[0] = 1'b0; tick(2);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(12);
    key_n_raw[0] = 1'b1; tick(12);
    key_n_raw[0] = 1'b0; tick(30);
    key_n_raw[0] = 1'b1; tick(12);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 299);
      b = $urandom_range(0, N - 1);
      if (r < 30) begin
        if (b < K) key_n_raw[b] = ~key_n_raw[b];
        else       sw_raw[b-K]  = ~sw_raw[b-K];
        tick(1);
      end else if (r < 40) begin
        if (b < K) key_n_raw[b] = ~key_n_raw[b];
        else       sw_raw[b-K]  = ~sw_raw[b-K];
        tick($urandom_range(1, D));
        if (b < K) key_n_raw[b] = ~key_n_raw[b];
        else       sw_raw[b-K]  = ~sw_raw[b-K];
        tick(1);
      end else if (r == 299) begin
        rst = 1'b1; tick($urandom_range(1, 3));
        rst = 1'b0; tick(1);
      end else begin
        tick(1);
      end
    end
    tick(12);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending events want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_switch_conditioner.md
Name: key_switch_conditioner

Overview:
- Board-side front end for the Nios II system's `keys` and `switches` PIO inputs.
- Synchronises the raw DE2 push-buttons and slide switches into the system clock domain, debounces them, and drives the clean levels into the PIO export ports.
- Also produces one-cycle press/release event pulses for hardware consumers, such as LED test logic.
- Sits directly upstream of the system's `keys_external_connection_export` and `switches_external_connection_export` inputs.

Parameters:
- NUM_KEYS, 3, number of push-buttons (raw inputs active-low).
- NUM_SW, 18, number of slide switches (active-high).
- DEBOUNCE_CYCLES, 500000, stable cycles required before a debounced bit changes (10 ms at 50 MHz); legal range ≥ 1. Counter width is derived internally with $clog2.
- REPEAT_DELAY, 25000000, cycles a key stays pressed before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses. Used only with the optional feature.

Ports:
- clk_clk  input  1  system clock (same clock as the Nios II system).
- reset_reset  input  1  synchronous, active-high reset.
- key_n_raw  input  NUM_KEYS  raw KEY pins, active-low, asynchronous.
- sw_raw  input  NUM_SW  raw SW pins, asynchronous.
- keys_export  output  NUM_KEYS  debounced keys, active-low (same polarity as the pins); feeds the keys PIO.
- switches_export  output  NUM_SW  debounced switches; feeds the switches PIO.
- key_press  output  NUM_KEYS  one-cycle pulse per key on a debounced press (1→0).
- key_release  output  NUM_KEYS  one-cycle pulse per key on a debounced release (0→1).
- sw_change  output  1  one-cycle pulse when any debounced switch bit changes.

Behaviour:
- All registers update on the rising edge of clk_clk. reset_reset is sampled synchronously only.
- Reset values:
  - keys_export = all ones (released).
  - switches_export = 0.
  - key_press, key_release and sw_change = 0.
  - Synchroniser flops are loaded with the same values as the matching stable outputs.
  - All counters = 0.
- Synchronisation: each raw bit passes through a 2-flop synchroniser (s1, then s2). Only s2 is used downstream.
- Per-bit debounce, identical for keys and switches; each bit has its own counter cnt:
  - If s2 == stable: cnt ← 0.
  - If s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - If s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable ← s2, cnt ← 0.
  - Any bounce back to the stable value restarts the count from 0.
- Latency: a raw level held constant from edge E onward appears on the export output after edge E+1+DEBOUNCE_CYCLES. Counted in edges, this is DEBOUNCE_CYCLES+2 edges including the sampling edge E.
- Event pulses are registered and asserted in the same cycle the debounced output changes. They are high for exactly one cycle.
  - key_press[i] = stable changed 1→0.
  - key_release[i] = stable changed 0→1.
  - sw_change = OR over all switch bits of (stable changed).
- Simultaneous events: bits are fully independent. Several pulses may assert in the same cycle.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never reaches the outputs.
- Reset mid-count: counters clear and outputs return to their reset values. A raw level still differing from the reset value is re-debounced from scratch and then produces a normal event pulse.
- Counters saturate by construction: a counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined: each key has a repeat counter that clears whenever its debounced key is released or reset is asserted.
  - While the key is debounced-pressed, key_press[i] re-pulses after REPEAT_DELAY cycles counted from the initial press pulse.
  - It then re-pulses every REPEAT_PERIOD cycles until release.
  - Release produces key_release and no further repeats.
- Undefined: no repeat counters are built. key_press fires only once per debounced press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; raw level changes just before edge E):
- Reset held 3 cycles with key_n_raw=3'b111, sw_raw=0 → keys_export=3'b111, switches_export=0, all pulses 0, throughout and after reset.
- key_n_raw[0] 1→0 at edge E and held → keys_export[0]=0 and key_press[0]=1 for exactly one cycle, after edge E+5. Releasing it likewise produces key_release[0] after 6 edges.
- key_n_raw[1] low 3 cycles, high 1, low 2, high 1, then low and held → no output change during the bounce. A single key_press[1] pulse occurs 6 edges after the final fall.
- sw_raw[17]=1 for 3 cycles then 0 → switches_export unchanged and no sw_change. sw_raw[17]=1 held → switches_export[17]=1 with a one-cycle sw_change after 6 edges.
- key_n_raw[0] and key_n_raw[2] fall on the same edge → key_press=3'b101 in a single cycle. Reset asserted 2 cycles into a count → outputs return to reset values, and the press is re-detected 6 edges after reset deassertion.
- With KEY_AUTOREPEAT_EN, KEY0 held 30 cycles → key_press[0] pulses at initial press, +10, +13, +16, … until release. Without the macro → exactly one pulse.
